// File: rtl/pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_ctrl
// Purpose  : PLL reset sequencing, LOCK filtering with retry/fail detection,
//            and runtime per-channel output-divider reconfiguration.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 7,
  parameter int DEF_DIV      = 50,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILT    = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic                    clkin,
  input  logic                    rst_n,
  input  logic                    pll_lock,
  output logic                    pll_reset,
  output logic [NUM_CH*DIV_W-1:0] odsel,
  output logic [NUM_CH-1:0]       ch_rst_n,
  input  logic                    cfg_req,
  input  logic [2:0]              cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    cfg_ack,
  output logic                    cfg_err,
  output logic                    locked,
  output logic                    pll_fail,
  output logic [7:0]              loss_cnt
);

  localparam int RST_W  = $clog2(RST_CYCLES + 1);
  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEF_DIV);
  localparam logic [2:0]        CH_LIMIT  = 3'(NUM_CH);

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_LOCK_FILT = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Assertion is asynchronous; release is aligned to clkin.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  logic lk_meta_q;
  logic lk_q;

  always_ff @(posedge clkin or negedge rst_int_n) begin
    if (!rst_int_n) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= pll_lock;
      lk_q      <= lk_meta_q;
    end
  end

  state_t              state_q;
  logic [RST_W-1:0]    rst_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [FILT_W-1:0]   filt_cnt_q;
  logic [RTY_W-1:0]    retry_q;
  logic [DIV_W-1:0]    odsel_q [NUM_CH];
  logic                pll_reset_q;
  logic [NUM_CH-1:0]   ch_rst_n_q;
  logic                cfg_ack_q;
  logic                cfg_err_q;
  logic                locked_q;
  logic                pll_fail_q;
  logic [7:0]          loss_cnt_q;

  logic cfg_valid;
  assign cfg_valid = (cfg_ch < CH_LIMIT) && (cfg_div != '0);

  always_ff @(posedge clkin or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_RST_HOLD;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      filt_cnt_q  <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ch_rst_n_q  <= '0;
      cfg_ack_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      pll_fail_q  <= 1'b0;
      loss_cnt_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        odsel_q[i] <= DIV_RST;
      end
    end else begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;

      case (state_q)
        ST_RST_HOLD: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q     <= ST_WAIT_LOCK;
            pll_reset_q <= 1'b0;
            to_cnt_q    <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lk_q) begin
            // This lk sample is the first of the consecutive-high run.
            if (LOCK_FILT == 1) begin
              state_q    <= ST_RUN;
              locked_q   <= 1'b1;
              ch_rst_n_q <= '1;
              retry_q    <= '0;
            end else begin
              state_q    <= ST_LOCK_FILT;
              filt_cnt_q <= FILT_W'(1);
            end
          end else if (to_cnt_q == TO_LAST) begin
            pll_reset_q <= 1'b1;
            if (retry_q < RTY_MAX) begin
              retry_q   <= retry_q + RTY_W'(1);
              state_q   <= ST_RST_HOLD;
              rst_cnt_q <= '0;
            end else begin
              state_q    <= ST_FAIL;
              pll_fail_q <= 1'b1;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        ST_LOCK_FILT: begin
          if (!lk_q) begin
            state_q  <= ST_WAIT_LOCK;
            to_cnt_q <= '0;
          end else if (filt_cnt_q == FILT_LAST) begin
            state_q    <= ST_RUN;
            locked_q   <= 1'b1;
            ch_rst_n_q <= '1;
            retry_q    <= '0;
          end else begin
            filt_cnt_q <= filt_cnt_q + FILT_W'(1);
          end
        end

        ST_RUN: begin
          if (!lk_q) begin
            if (loss_cnt_q != 8'hFF) begin
              loss_cnt_q <= loss_cnt_q + 8'd1;
            end
            state_q     <= ST_RST_HOLD;
            rst_cnt_q   <= '0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            ch_rst_n_q  <= '0;
          end else if (cfg_req && !cfg_ack_q) begin
            // The ack from last cycle is still visible to the requester, so
            // its level request is not taken a second time.
            cfg_ack_q <= 1'b1;
            if (cfg_valid) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == 3'(i)) begin
                  odsel_q[i] <= cfg_div;
                end
              end
              state_q     <= ST_RST_HOLD;
              rst_cnt_q   <= '0;
              pll_reset_q <= 1'b1;
              locked_q    <= 1'b0;
              ch_rst_n_q  <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        ST_FAIL: begin
          pll_reset_q <= 1'b1;
          pll_fail_q  <= 1'b1;
          ch_rst_n_q  <= '0;
          locked_q    <= 1'b0;
        end

        default: begin
          state_q     <= ST_RST_HOLD;
          rst_cnt_q   <= '0;
          pll_reset_q <= 1'b1;
          locked_q    <= 1'b0;
          ch_rst_n_q  <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_odsel
    assign odsel[g*DIV_W +: DIV_W] = odsel_q[g];
  end

  assign pll_reset = pll_reset_q;
  assign ch_rst_n  = ch_rst_n_q;
  assign cfg_ack   = cfg_ack_q;
  assign cfg_err   = cfg_err_q;
  assign locked    = locked_q;
  assign pll_fail  = pll_fail_q;
  assign loss_cnt  = loss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
`default_nettype none
// tb_pll_lock_ctrl: directed scenarios checked every cycle against a phase-level
// reference model, plus literal timing/value expectations.
module tb_pll_lock_ctrl;

  localparam int NUM_CH       = 4;
  localparam int DIV_W        = 7;
  localparam int DEF_DIV      = 50;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_FILT    = 8;
  localparam int LOCK_TIMEOUT = 100;
  localparam int MAX_RETRY    = 2;
  localparam int OW           = NUM_CH * DIV_W;

  localparam int P_HOLD = 0;
  localparam int P_ACQ  = 1;
  localparam int P_RUN  = 2;
  localparam int P_FAIL = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll_lock = 1'b0;
  logic              cfg_req = 1'b0;
  logic [2:0]        cfg_ch = 3'd0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              pll_reset;
  logic [OW-1:0]     odsel;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              cfg_ack;
  logic              cfg_err;
  logic              locked;
  logic              pll_fail;
  logic [7:0]        loss_cnt;

  always #5 clk = ~clk;

  pll_lock_ctrl #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .RST_CYCLES(RST_CYCLES),
    .LOCK_FILT(LOCK_FILT), .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clkin(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .odsel(odsel), .ch_rst_n(ch_rst_n), .cfg_req(cfg_req), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .locked(locked),
    .pll_fail(pll_fail), .loss_cnt(loss_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: HOLD / ACQ(uire, wait+filter merged) / RUN / FAIL.
  int m_phase, m_held, m_zeros, m_ones, m_retry, m_loss, m_act;
  int m_div [NUM_CH];
  bit m_ack, m_err, m_h1, m_h2;

  task automatic model_reset();
    m_phase = P_HOLD; m_held = 0; m_zeros = 0; m_ones = 0; m_retry = 0;
    m_loss = 0; m_act = 0; m_ack = 0; m_err = 0; m_h1 = 0; m_h2 = 0;
    for (int i = 0; i < NUM_CH; i++) m_div[i] = DEF_DIV;
  endtask

  task automatic model_step();
    bit l, prev_ack;
    l = m_h2; m_h2 = m_h1; m_h1 = pll_lock;
    prev_ack = m_ack;
    m_ack = 0; m_err = 0;
    case (m_phase)
      P_HOLD: begin
        m_held++;
        if (m_held == RST_CYCLES) begin
          m_phase = P_ACQ; m_zeros = 0; m_ones = 0;
        end
      end
      P_ACQ: begin
        if (l) begin
          m_ones++;
          if (m_ones == LOCK_FILT) begin m_phase = P_RUN; m_retry = 0; end
        end else if (m_ones > 0) begin
          m_ones = 0; m_zeros = 0;
        end else begin
          m_zeros++;
          if (m_zeros == LOCK_TIMEOUT) begin
            if (m_retry < MAX_RETRY) begin
              m_retry++; m_phase = P_HOLD; m_held = 0;
            end else begin
              m_phase = P_FAIL;
            end
          end
        end
      end
      P_RUN: begin
        if (!l) begin
          if (m_loss < 255) m_loss++;
          m_phase = P_HOLD; m_held = 0;
        end else if (cfg_req && !prev_ack) begin
          m_ack = 1;
          if (int'(cfg_ch) < NUM_CH && cfg_div != 0) begin
            m_div[cfg_ch] = int'(cfg_div);
            m_phase = P_HOLD; m_held = 0;
          end else begin
            m_err = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (m_act < 2) m_act++;
      else model_step();
    end
  end

  initial begin
    logic [OW-1:0] m_od;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) m_od[i*DIV_W +: DIV_W] = m_div[i][DIV_W-1:0];
      check("pll_reset", 64'(pll_reset), 64'(m_phase == P_HOLD || m_phase == P_FAIL));
      check("locked",    64'(locked),    64'(m_phase == P_RUN));
      check("ch_rst_n",  64'(ch_rst_n),  (m_phase == P_RUN) ? 64'hF : 64'h0);
      check("pll_fail",  64'(pll_fail),  64'(m_phase == P_FAIL));
      check("odsel",     64'(odsel),     64'(m_od));
      check("cfg_ack",   64'(cfg_ack),   64'(m_ack));
      check("cfg_err",   64'(cfg_err),   64'(m_err));
      check("loss_cnt",  64'(loss_cnt),  64'(m_loss));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    pll_lock = 1'b0;
    cfg_req = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic measure(input logic lvl, input int budget, output int n);
    n = 0;
    while (pll_reset === lvl && n < budget) begin tick(1); n++; end
  endtask

  task automatic wait_locked(input string name, input int budget);
    int n;
    n = 0;
    while (locked !== 1'b1 && n < budget) begin tick(1); n++; end
    check(name, 64'(n < budget), 64'd1);
  endtask

  task automatic cfg_request(input logic [2:0] ch, input logic [DIV_W-1:0] dv, output int n);
    cfg_ch = ch; cfg_div = dv; cfg_req = 1'b1;
    n = 0;
    while (cfg_ack !== 1'b1 && n < 10) begin tick(1); n++; end
  endtask

  initial begin
    int n, acks;
    logic [OW-1:0] exp_od;
    tick(3);

    // Nominal lock: 2 synchroniser cycles + 4 hold cycles, then 2+8 to locked.
    apply_reset();
    measure(1'b1, 50, n);
    check("rst_release_to_pll_reset_low", 64'(n), 64'd6);
    tick(10);
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 40) begin tick(1); n++; end
    check("nominal_lock_latency", 64'(n), 64'd10);
    exp_od = {4{7'd50}};
    check("nominal_odsel", 64'(odsel), 64'(exp_od));
    check("nominal_ch_rst_n", 64'(ch_rst_n), 64'hF);

    // Glitchy lock: high 5, low 1, then steady; locked 10 cycles after last rise.
    apply_reset();
    measure(1'b1, 50, n);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 40) begin tick(1); n++; end
    check("glitch_lock_latency", 64'(n), 64'd10);

    // Timeout and fail: three 4-cycle pulses separated by 100-cycle waits.
    apply_reset();
    measure(1'b1, 50, n);
    measure(1'b0, 200, n); check("timeout_wait1", 64'(n), 64'd100);
    measure(1'b1, 200, n); check("retry_pulse1", 64'(n), 64'd4);
    measure(1'b0, 200, n); check("timeout_wait2", 64'(n), 64'd100);
    measure(1'b1, 200, n); check("retry_pulse2", 64'(n), 64'd4);
    measure(1'b0, 200, n); check("timeout_wait3", 64'(n), 64'd100);
    check("fail_flag", 64'(pll_fail), 64'd1);
    pll_lock = 1'b1;
    tick(40);
    check("fail_sticky", 64'(pll_fail), 64'd1);
    check("fail_pll_reset", 64'(pll_reset), 64'd1);
    check("fail_not_locked", 64'(locked), 64'd0);

    // Lock loss: one-cycle drop, seen after synchroniser plus registered output.
    apply_reset();
    measure(1'b1, 50, n);
    pll_lock = 1'b1;
    wait_locked("loss_initial_lock", 60);
    tick(3);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    n = 1;
    while (locked === 1'b1 && n < 20) begin tick(1); n++; end
    check("loss_detect_latency", 64'(n), 64'd3);
    check("loss_ch_rst_n", 64'(ch_rst_n), 64'h0);
    check("loss_count", 64'(loss_cnt), 64'd1);
    measure(1'b1, 50, n);
    check("loss_reset_pulse", 64'(n), 64'd4);
    wait_locked("loss_relock", 60);

    // Reconfigure channel 2 to divider 12.
    tick(2);
    cfg_request(3'd2, 7'd12, n);
    check("cfg_ack_latency", 64'(n), 64'd1);
    check("cfg_no_err", 64'(cfg_err), 64'd0);
    check("cfg_leaves_run", 64'(locked), 64'd0);
    cfg_req = 1'b0;
    exp_od = {7'd50, 7'd12, 7'd50, 7'd50};
    check("cfg_odsel", 64'(odsel), 64'(exp_od));
    wait_locked("cfg_relock", 60);
    check("cfg_odsel_after_relock", 64'(odsel), 64'(exp_od));

    // Rejected requests: bad channel, zero divider.
    tick(2);
    cfg_request(3'd5, 7'd9, n);
    check("rej_ch_ack", 64'(n), 64'd1);
    check("rej_ch_err", 64'(cfg_err), 64'd1);
    cfg_req = 1'b0;
    tick(1);
    check("rej_ch_stays_run", 64'(locked), 64'd1);
    check("rej_ch_single_ack", 64'(cfg_ack), 64'd0);
    check("rej_ch_odsel", 64'(odsel), 64'(exp_od));
    cfg_request(3'd1, 7'd0, n);
    check("rej_div_ack", 64'(n), 64'd1);
    check("rej_div_err", 64'(cfg_err), 64'd1);
    cfg_req = 1'b0;
    tick(1);
    check("rej_div_stays_run", 64'(locked), 64'd1);
    check("rej_div_odsel", 64'(odsel), 64'(exp_od));

    // Collision: request reaches RUN in the same cycle as the lock loss.
    tick(2);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    cfg_ch = 3'd1; cfg_div = 7'd33; cfg_req = 1'b1;
    tick(1);
    check("coll_lock_lost", 64'(locked), 64'd0);
    check("coll_no_ack", 64'(cfg_ack), 64'd0);
    check("coll_loss_count", 64'(loss_cnt), 64'd2);
    n = 0; acks = 0;
    while (locked !== 1'b1 && n < 60) begin
      if (cfg_ack === 1'b1) acks++;
      tick(1); n++;
    end
    check("coll_acks_before_run", 64'(acks), 64'd0);
    n = 0;
    while (cfg_ack !== 1'b1 && n < 10) begin tick(1); n++; end
    check("coll_ack_after_run", 64'(n), 64'd1);
    check("coll_ack_no_err", 64'(cfg_err), 64'd0);
    cfg_req = 1'b0;
    exp_od = {7'd50, 7'd12, 7'd33, 7'd50};
    check("coll_odsel", 64'(odsel), 64'(exp_od));
    wait_locked("coll_relock", 60);

    // Asynchronous reset mid-RUN.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_od = {4{7'd50}};
    check("arst_odsel", 64'(odsel), 64'(exp_od));
    check("arst_locked", 64'(locked), 64'd0);
    check("arst_loss_cnt", 64'(loss_cnt), 64'd0);
    check("arst_pll_reset", 64'(pll_reset), 64'd1);
    check("arst_ch_rst_n", 64'(ch_rst_n), 64'h0);
    tick(2);
    rst_n = 1'b1;
    measure(1'b1, 50, n);
    check("arst_release_to_pll_reset_low", 64'(n), 64'd6);
    wait_locked("arst_relock", 60);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
- Parametrised controller for the dynamic-divider PLL used for camera and pixel clocks; generalises the fixed single-output, static-divider PLL setup.
- Sequences PLL reset and filters LOCK; retries and flags failure on lock timeout.
- Drives per-channel output-divider selects at runtime through a req/ack handshake and gates a per-channel reset to downstream logic.
- Runs on the PLL reference clock. The PLL primitive is instantiated beside it, not inside.

Parameters:
- NUM_CH, 4, output channels controlled (1..7)
- DIV_W, 7, divider select width per channel
- DEF_DIV, 50, divider loaded into every channel at reset
- RST_CYCLES, 16, cycles pll_reset is held high per reset pulse (>=2)
- LOCK_FILT, 64, consecutive LOCK-high cycles required before RUN (>=1)
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry
- MAX_RETRY, 3, retries before declaring failure

Ports:
- clkin  input  1  reference clock, also the PLL input clock
- rst_n  input  1  asynchronous active-low reset
- pll_lock  input  1  PLL LOCK; asynchronous, double-flopped internally
- pll_reset  output  1  active-high reset to PLL
- odsel  output  NUM_CH*DIV_W  divider selects, channel i at bits [i*DIV_W +: DIV_W]
- ch_rst_n  output  NUM_CH  active-low per-channel downstream reset
- cfg_req  input  1  reconfiguration request, level; held until cfg_ack
- cfg_ch  input  3  target channel
- cfg_div  input  DIV_W  new divider
- cfg_ack  output  1  one-cycle pulse, request consumed
- cfg_err  output  1  one-cycle pulse coincident with cfg_ack when the request is rejected
- locked  output  1  high only in RUN
- pll_fail  output  1  sticky failure flag
- loss_cnt  output  8  lock-loss event counter, saturating at 255

Behaviour:
- Reset (rst_n=0): state RST_HOLD; pll_reset=1; odsel all channels=DEF_DIV; ch_rst_n=0; cfg_ack=0; cfg_err=0; locked=0; pll_fail=0; loss_cnt=0; retry count=0.
- pll_lock passes through a 2-flop synchroniser. All lock decisions use the synchronised value lk, which adds 2 cycles of latency.
- RST_HOLD: pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_reset=0.
- WAIT_LOCK:
  - lk=1 -> LOCK_FILT.
  - After LOCK_TIMEOUT cycles without lk: if retries<MAX_RETRY, increment retries and go to RST_HOLD; otherwise go to FAIL.
- LOCK_FILT:
  - Counts consecutive lk=1 cycles; any lk=0 returns to WAIT_LOCK with the timeout counter restarted.
  - On reaching LOCK_FILT count: go to RUN, retries=0.
- RUN:
  - locked=1 and ch_rst_n all 1, both registered on RUN entry.
  - lk=0 -> loss_cnt+1 (saturating), locked=0, ch_rst_n=0 in the same cycle, go to RST_HOLD.
- FAIL: pll_reset=1, pll_fail=1, ch_rst_n=0. Left only by rst_n.
- cfg handshake, sampled only in RUN:
  - cfg_req=1 with cfg_ch<NUM_CH and cfg_div!=0: write odsel[cfg_ch]=cfg_div, pulse cfg_ack, drive ch_rst_n[cfg_ch]=0, go to RST_HOLD. The full relock sequence follows; all channels reset meanwhile.
  - Invalid request (cfg_ch>=NUM_CH or cfg_div==0): cfg_ack and cfg_err pulse together, odsel unchanged, stay in RUN.
  - cfg_req outside RUN is held off with no ack. The requester keeps cfg_req high; it is serviced on the first RUN cycle.
  - Lock loss and cfg_req in the same RUN cycle: lock loss wins; the request stays pending.
- odsel changes only on an accepted request or on reset. Never glitches mid-sequence.
- Counter widths are clog2(param+1). LOCK_TIMEOUT counter restarts on every WAIT_LOCK entry.
- rst_n assertion mid-operation returns all state to reset values asynchronously. Release is synchronous to clkin through a 2-flop reset synchroniser.

Test Plan:
- Use RST_CYCLES=4, LOCK_FILT=8, LOCK_TIMEOUT=100, MAX_RETRY=2 unless noted.
- Nominal lock: release rst_n, raise pll_lock 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; locked rises 2+8 cycles after pll_lock rises; odsel = 50 in every field.
- Glitchy lock: pll_lock high 5 cycles, low 1, then steady -> no RUN entry until 8 consecutive synchronised-high cycles; locked timing counted from the last rise.
- Timeout and fail: pll_lock held 0 -> three reset pulses of 4 cycles (initial + 2 retries) spaced by 100-cycle waits, then pll_fail=1 and pll_reset=1 permanently; a late pll_lock is ignored.
- Lock loss: in RUN, drop pll_lock for 1 cycle -> 2 cycles later locked=0 and ch_rst_n=0, loss_cnt=1, a new 4-cycle reset pulse, relock.
- Reconfig: cfg_req ch=2 div=12 in RUN -> one cfg_ack pulse, odsel[20:14]=12 with other fields unchanged, relock sequence, locked again.
- Rejects and collision: cfg_ch=5 (NUM_CH=4) -> cfg_ack+cfg_err, no state change. cfg_div=0 -> same. cfg_req on the same cycle as lock loss -> no ack until the next RUN, then accepted.
